// File: rtl/button_debouncer.sv
// Push-button conditioner: pin synchroniser, 4-state debounce FSM, and registered
// level / press / release / long-press outputs for downstream edge and control logic.
module button_debouncer #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 1000000,
  parameter int LONG_CNT     = 100000000,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [1:0] state
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam int HW = (LONG_CNT < 1) ? 1 : $clog2(LONG_CNT + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);
  localparam logic [HW-1:0] LONG_LAST = (LONG_CNT == 0) ? '0 : HW'(LONG_CNT - 1);
  localparam bit            LONG_EN   = (LONG_CNT != 0);

  typedef enum logic [1:0] {
    S_RELEASED    = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_PRESSED     = 2'd2,
    S_RELEASE_CHK = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_in;
  logic                   w_s_in;

  state_t        r_state,     w_state_nxt;
  logic [CW-1:0] r_cnt,       w_cnt_nxt;
  logic [HW-1:0] r_hold,      w_hold_nxt;
  logic          r_long_done, w_long_done_nxt;
  logic          r_level,     w_level_nxt;
  logic          r_press,     w_press_nxt;
  logic          r_release,   w_release_nxt;
  logic          r_long,      w_long_nxt;

  // Polarity is folded in ahead of the synchroniser so reset clears to "released".
  assign w_in   = btn_raw ^ ACTIVE_LOW;
  assign w_s_in = r_sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RELEASED;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_long_done <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_long_done <= w_long_done_nxt;
      r_level     <= w_level_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_long      <= w_long_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_long_done_nxt = r_long_done;
    w_level_nxt     = r_level;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_long_nxt      = 1'b0;

    unique case (r_state)
      S_RELEASED: begin
        w_level_nxt = 1'b0;
        if (w_s_in) begin
          w_state_nxt = S_PRESS_CHK;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_CHK: begin
        if (!w_s_in) begin
          w_state_nxt = S_RELEASED;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt     = S_PRESSED;
          w_level_nxt     = 1'b1;
          w_press_nxt     = 1'b1;
          w_hold_nxt      = '0;
          w_long_done_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_PRESSED: begin
        if (!w_s_in) begin
          w_state_nxt = S_RELEASE_CHK;
          w_cnt_nxt   = '0;
        end else if (LONG_EN && !r_long_done && (r_hold == LONG_LAST)) begin
          w_long_nxt      = 1'b1;
          w_long_done_nxt = 1'b1;
        end else if (LONG_EN && !r_long_done) begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      S_RELEASE_CHK: begin
        // hold_cnt and long_done are left untouched so a rejected bounce resumes the hold.
        if (w_s_in) begin
          w_state_nxt = S_PRESSED;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt   = S_RELEASED;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_RELEASED;
    endcase
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;
  assign state         = r_state;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: four configurations share one stimulus stream and are
// checked every cycle against a run-length model, plus literal timing expectations.
module tb_button_debouncer;

  localparam int NI = 4;
  // Instances: 0 = nominal, 1 = long disabled, 2 = active-low pin, 3 = minimal debounce.
  localparam int P_SYNC [NI] = '{2, 2, 2, 3};
  localparam int P_DEB  [NI] = '{4, 4, 4, 1};
  localparam int P_LONG [NI] = '{10, 0, 10, 1};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic       btn_n;
  logic       lvl [NI];
  logic       prs [NI];
  logic       rls [NI];
  logic       lng [NI];
  logic [1:0] st  [NI];

  assign btn_n = ~btn;

  always #5 clk = ~clk;

  button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CNT(4), .LONG_CNT(10), .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn), .btn_level(lvl[0]), .press_pulse(prs[0]),
    .release_pulse(rls[0]), .long_pulse(lng[0]), .state(st[0]));
  button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CNT(4), .LONG_CNT(0), .ACTIVE_LOW(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn), .btn_level(lvl[1]), .press_pulse(prs[1]),
    .release_pulse(rls[1]), .long_pulse(lng[1]), .state(st[1]));
  button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CNT(4), .LONG_CNT(10), .ACTIVE_LOW(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_n), .btn_level(lvl[2]), .press_pulse(prs[2]),
    .release_pulse(rls[2]), .long_pulse(lng[2]), .state(st[2]));
  button_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CNT(1), .LONG_CNT(1), .ACTIVE_LOW(1'b0)) u_d (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn), .btn_level(lvl[3]), .press_pulse(prs[3]),
    .release_pulse(rls[3]), .long_pulse(lng[3]), .state(st[3]));

  // Model: the accepted level flips once the synchronised input has disagreed with it
  // on DEBOUNCE_CNT+1 consecutive edges; held time accrues only on agreeing edges.
  bit m_level [NI];
  int m_run   [NI];
  int m_held  [NI];
  bit m_done  [NI];
  bit m_press [NI];
  bit m_rel   [NI];
  bit m_long  [NI];
  bit hist    [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < NI; i++) begin
        m_level[i] = 1'b0; m_run[i] = 0; m_held[i] = 0; m_done[i] = 1'b0;
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_long[i] = 1'b0;
      end
    end else begin
      hist.push_front(btn);
      if (hist.size() > 8) void'(hist.pop_back());
      for (int i = 0; i < NI; i++) begin
        bit s;
        s = (hist.size() > P_SYNC[i]) ? hist[P_SYNC[i]] : 1'b0;
        m_press[i] = 1'b0; m_rel[i] = 1'b0; m_long[i] = 1'b0;
        if (s != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == P_DEB[i] + 1) begin
            m_level[i] = s;
            m_run[i]   = 0;
            if (s) begin
              m_press[i] = 1'b1; m_held[i] = 0; m_done[i] = 1'b0;
            end else begin
              m_rel[i] = 1'b1;
            end
          end
        end else begin
          if (m_level[i] && m_run[i] == 0 && P_LONG[i] != 0 && !m_done[i]) begin
            m_held[i]++;
            if (m_held[i] == P_LONG[i]) begin
              m_long[i] = 1'b1; m_done[i] = 1'b1;
            end
          end
          m_run[i] = 0;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_press [NI];
  int cnt_rel   [NI];
  int cnt_long  [NI];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [5:0] g, e;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      g = {lvl[i], prs[i], rls[i], lng[i], st[i]};
      e = {m_level[i], m_press[i], m_rel[i], m_long[i], m_level[i], (m_run[i] != 0)};
      check($sformatf("model inst%0d {lvl,prs,rls,lng,state}", i), 32'(g), 32'(e));
      cnt_press[i] += int'(prs[i]);
      cnt_rel[i]   += int'(rls[i]);
      cnt_long[i]  += int'(lng[i]);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("async reset inst%0d outputs", i),
            32'({lvl[i], prs[i], rls[i], lng[i], st[i]}), 32'd0);
    wait_n(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int snap_a, snap_b;
    int len;
    logic [6:0] e7;
    for (int i = 0; i < NI; i++) begin
      cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0;
    end

    wait_n(3);
    rst_n = 1'b1;
    wait_n(5);
    btn = 1'b1;
    wait_n(10);
    check("pressed before reset", 32'(lvl[0]), 32'd1);

    // Reset while the button is held, then time the re-acceptance from release.
    async_reset();
    for (int k = 1; k <= 8; k++) begin
      tick();
      e7 = {k >= 7, k == 7, k >= 7, k == 7, k >= 5, k == 5, k == 6};
      check($sformatf("press timing edge %0d", k),
            32'({lvl[0], prs[0], lvl[2], prs[2], lvl[3], prs[3], lng[3]}), 32'(e7));
    end
    check("state pressed", 32'(st[0]), 32'd2);

    wait_n(8);
    check("long not yet (edge 16)", 32'(lng[0]), 32'd0);
    tick();
    check("long at edge 17", 32'({lng[0], lng[2]}), 32'b11);
    tick();
    check("long one cycle", 32'(lng[0]), 32'd0);

    snap_a = cnt_long[0];
    wait_n(50);
    check("no second long", 32'(cnt_long[0] - snap_a), 32'd0);

    // Release bounce: low 2, high 1, low held.
    snap_b = cnt_rel[0];
    btn = 1'b0; wait_n(2);
    btn = 1'b1; wait_n(1);
    btn = 1'b0; wait_n(6);
    check("release bounce level held", 32'({lvl[0], st[0][1]}), 32'b11);
    check("release bounce no pulse", 32'(cnt_rel[0] - snap_b), 32'd0);
    tick();
    check("release accepted edge 7", 32'({lvl[0], rls[0]}), 32'b01);
    check("bounce no long retrigger", 32'(cnt_long[0] - snap_a), 32'd0);

    // Press bounce: high 3, low 1, high held.
    wait_n(5);
    snap_a = cnt_press[0];
    btn = 1'b1; wait_n(3);
    btn = 1'b0; wait_n(1);
    btn = 1'b1; wait_n(2);
    check("press bounce back to released", 32'(st[0]), 32'd0);
    wait_n(4);
    check("press bounce edge 6", 32'(lvl[0]), 32'd0);
    tick();
    check("press bounce edge 7", 32'({lvl[0], prs[0]}), 32'b11);
    wait_n(3);
    check("press bounce single pulse", 32'(cnt_press[0] - snap_a), 32'd1);

    // Randomised bouncing and long holds, with occasional asynchronous resets.
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 3) != 0) btn = ~btn;
        case ($urandom_range(0, 9))
          0, 1, 2, 3: len = $urandom_range(1, 4);
          4, 5, 6, 7: len = $urandom_range(4, 12);
          default:    len = $urandom_range(12, 40);
        endcase
        wait_n(len);
      end
    end
    btn = 1'b0;
    wait_n(10);

    check("long disabled never pulses", 32'(cnt_long[1]), 32'd0);
    check("idle released at end", 32'({lvl[0], st[0]}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
